// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and constants: NOP bubble word, PC-source encodings
// and the fetch FSM states.
package riscv_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;

    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [1:0] PCSRC_PLUS4  = 2'b00;
    localparam logic [1:0] PCSRC_TARGET = 2'b01;
    localparam logic [1:0] PCSRC_JALR   = 2'b10;

    typedef enum logic [1:0] {
        REQ     = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/ready handshake between fetch (master) and imem (slave).
interface fetch_stage_if #(
    parameter int unsigned XLEN = riscv_pkg::XLEN
);
    logic            imemReq;
    logic [XLEN-1:0] imemAddr;
    logic            imemReady;
    logic [31:0]     imemRdata;

    modport master (output imemReq, imemAddr, input imemReady, imemRdata);
    modport slave  (input imemReq, imemAddr, output imemReady, imemRdata);
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: clear (reset or flush) loads a bubble and dominates enable.
module if_id_reg
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = riscv_pkg::XLEN
) (
    input  logic            clk,
    input  logic            clear_i,
    input  logic            en_i,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] pc_plus4_i,
    input  logic            valid_i,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic            valid_o
);

    always_ff @(posedge clk) begin
        if (clear_i) begin
            instr_o    <= NOP_INSTR;
            pc_o       <= '0;
            pc_plus4_o <= '0;
            valid_o    <= 1'b0;
        end else if (en_i) begin
            instr_o    <= instr_i;
            pc_o       <= pc_i;
            pc_plus4_o <= pc_plus4_i;
            valid_o    <= valid_i;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns PCF, drives the imem handshake, holds a word fetched
// under stall and discards responses that land after a redirect.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter int unsigned     XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stallF,
    input  logic            stallD,
    input  logic            flushD,
    input  logic [1:0]      PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    input  logic [XLEN-1:0] ALUResultE,
    fetch_stage_if.master   imem,
    output logic [31:0]     instrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            validD
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pcf_q, pcf_d;
    logic [31:0]     hold_instr_q, hold_instr_d;
    logic [XLEN-1:0] pend_target_q, pend_target_d;

    logic            redirect, stall, deliver;
    logic [XLEN-1:0] target, pcf_plus4;
    logic [31:0]     deliver_instr;

    assign redirect  = (PCSrcE != PCSRC_PLUS4);
    assign stall     = stallF | stallD;
    assign target    = ((PCSrcE == PCSRC_JALR) ? ALUResultE : PCTargetE) & ~XLEN'(3);
    assign pcf_plus4 = pcf_q + XLEN'(4);

    assign imem.imemReq  = (state_q != HOLD) && !rst;
    assign imem.imemAddr = pcf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= REQ;
            pcf_q         <= RESET_PC;
            hold_instr_q  <= '0;
            pend_target_q <= '0;
        end else begin
            state_q       <= state_d;
            pcf_q         <= pcf_d;
            hold_instr_q  <= hold_instr_d;
            pend_target_q <= pend_target_d;
        end
    end

    // Redirect always wins over stall; a deliver advances PCF by one word.
    always_comb begin
        state_d       = state_q;
        pcf_d         = pcf_q;
        hold_instr_d  = hold_instr_q;
        pend_target_d = pend_target_q;
        deliver       = 1'b0;
        deliver_instr = imem.imemRdata;
        unique case (state_q)
            REQ: begin
                if (imem.imemReady) begin
                    if (redirect) begin
                        pcf_d = target;
                    end else if (stall) begin
                        hold_instr_d = imem.imemRdata;
                        state_d      = HOLD;
                    end else begin
                        deliver = 1'b1;
                        pcf_d   = pcf_plus4;
                    end
                end else if (redirect) begin
                    pend_target_d = target;
                    state_d       = DISCARD;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pcf_d   = target;
                    state_d = REQ;
                end else if (!stall) begin
                    deliver       = 1'b1;
                    deliver_instr = hold_instr_q;
                    pcf_d         = pcf_plus4;
                    state_d       = REQ;
                end
            end
            DISCARD: begin
                if (redirect) begin
                    pend_target_d = target;
                end
                if (imem.imemReady) begin
                    pcf_d   = redirect ? target : pend_target_q;
                    state_d = REQ;
                end
            end
            default: state_d = REQ;
        endcase
    end

    if_id_reg #(.XLEN(XLEN)) u_if_id (
        .clk        (clk),
        .clear_i    (rst | flushD),
        .en_i       (!stallD),
        .instr_i    (deliver ? deliver_instr : NOP_INSTR),
        .pc_i       (deliver ? pcf_q : '0),
        .pc_plus4_i (deliver ? pcf_plus4 : '0),
        .valid_i    (deliver),
        .instr_o    (instrD),
        .pc_o       (PCD),
        .pc_plus4_o (PCPlus4D),
        .valid_o    (validD)
    );

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined RISC-V core: owns PCF, talks to instruction memory over a request/ready handshake, and loads the IF/ID pipeline register consumed by decode. It sits directly upstream of decode and obeys the hazard unit's stallF/stallD/flushD and the execute stage's PCSrcE redirect. A small FSM tolerates multi-cycle memory, holding an instruction fetched during a stall and discarding responses that arrive after a redirect.

## Interface
- XLEN, 32, datapath width
- RESET_PC, 32'h0000_0000, PCF value after reset

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stallF  in  1  hazard unit: hold fetch
- stallD  in  1  hazard unit: hold IF/ID register
- flushD  in  1  hazard unit: load bubble into IF/ID
- PCSrcE  in  2  00 PC+4, 01 PCTargetE, 10 ALUResultE (jalr), 11 treated as 01
- PCTargetE  in  XLEN  branch/jal target
- ALUResultE  in  XLEN  jalr target
- imemReq  out  1  fetch request valid
- imemAddr  out  XLEN  fetch address; stable while imemReq && !imemReady
- imemReady  in  1  transfer completes this cycle; imemRdata valid
- imemRdata  in  32  instruction word
- instrD  out  32  decode instruction
- PCD  out  XLEN  PC of instrD
- PCPlus4D  out  XLEN  PCD+4
- validD  out  1  instrD is a real instruction (0 = bubble)

## Operation
- Bubble = instrD 32'h0000_0013 (addi x0,x0,0), validD 0, PCD 0, PCPlus4D 0.
- Internal stall = stallF | stallD (stallD without stallF is not generated; treated as stall).
- Redirect = PCSrcE != 00; target bits [1:0] forced to 0; 10 selects ALUResultE, else PCTargetE. Redirect has priority over stall.
- PC arithmetic modulo 2^XLEN; 32'hFFFF_FFFC+4 wraps to 0.
- States: REQ, HOLD, DISCARD. imemReq = (state != HOLD) && !rst; imemAddr = PCF.
- REQ, imemReady, redirect: drop data, PCF <= target, stay REQ.
- REQ, imemReady, stall: holdInstr <= imemRdata, go HOLD, PCF unchanged.
- REQ, imemReady, otherwise: deliver {imemRdata, PCF}; PCF <= PCF+4.
- REQ, !imemReady, redirect: pendTarget <= target, go DISCARD; PCF unchanged (address stable).
- HOLD: redirect -> drop holdInstr, PCF <= target, REQ; stall -> stay; else deliver {holdInstr, PCF}, PCF <= PCF+4, REQ.
- DISCARD: redirect overwrites pendTarget; on imemReady drop data, PCF <= (redirect this cycle ? target : pendTarget), REQ.
- IF/ID update priority: rst -> bubble; flushD -> bubble; stallD -> hold; deliver -> load; else bubble.

## Timing
- Reset: PCF=RESET_PC, state REQ, IF/ID = bubble, imemReq 0 during reset, 1 the first cycle after.
- Reset mid-transaction abandons the request; memory shares rst.
- Zero-wait memory (imemReady=1): one instruction per cycle; word at PCF in cycle t appears in instrD cycle t+1.
- Redirect in cycle t: PCF=target in t+1; flushD bubbles IF/ID at edge ending t; target instruction in instrD cycle t+2.
- Stall: PCF and IF/ID frozen exactly for cycles stallF/stallD high; no instruction lost or duplicated.
- Memory latency N cycles: N-1 bubbles into decode per fetch.

## Structure
- riscv_pkg: NOP_INSTR, PCSrc encodings (PCSRC_PLUS4, PCSRC_TARGET, PCSRC_JALR), fetch_state_t {REQ, HOLD, DISCARD}.
- Sub-module if_id_reg: 3×XLEN+1 register with synchronous clear (rst|flushD) and enable (!stallD), clear dominant.
- FSM, PCF, holdInstr, pendTarget and next-PC mux in fetch_stage.

## Test plan
- Reset, imemReady=1, memory returns addr-tagged words -> instrD sequence for PCs 0,4,8,... one per cycle, validD=1 from cycle 2.
- PCSrcE=01, PCTargetE=0x100 in cycle t -> instrD bubble at t+1, word@0x100 with PCD=0x100 at t+2; PCSrcE=10, ALUResultE=0x203 -> fetch 0x200.
- stallF=stallD=1 for 3 cycles with ready=1 -> state HOLD, PCF and instrD frozen; on release held word delivered once, then PCF+4.
- imemReady delayed 3 cycles, redirect to 0x40 in 2nd wait cycle -> imemAddr stable, response dropped, next request 0x40, no stale instr with validD=1.
- Redirect and stallF same cycle -> redirect wins, PCF=target; flushD and stallD same cycle -> bubble.
- rst asserted during DISCARD -> next cycle PCF=RESET_PC, state REQ, IF/ID bubble; PCF=0xFFFFFFFC sequential -> wraps to 0.
